// File: rtl/ikaopll_dac_seq.sv
// ikaopll_dac_seq: DAC slot timing, soft-mute volume ramp and strobe-captured sample FIFO.
module ikaopll_dac_seq #(
    parameter logic [17:0] FM_MASK_MEL = 18'h3232B,
    parameter logic [17:0] FM_MASK_RHY = 18'h32320,
    parameter logic [17:0] RO_MASK_RHY = 18'h0001F,
    parameter int          FIFO_DEPTH  = 4
) (
    input  logic        i_EMUCLK,
    input  logic        i_RST_n,
    input  logic        i_phi1_NCEN_n,
    input  logic        i_RHYTHM_EN,
    input  logic        i_MUTE_REQ,
    input  logic [3:0]  i_TGT_MOVOL,
    input  logic [3:0]  i_TGT_ROVOL,
    output logic        o_CYCLE_00,
    output logic        o_MO_CTRL,
    output logic        o_RO_CTRL,
    output logic        o_DAC_EN,
    output logic [3:0]  o_MOVOL,
    output logic [3:0]  o_ROVOL,
    input  logic        i_ACC_STRB,
    input  logic [15:0] i_ACC_DATA,
    output logic        o_SMPL_VALID,
    input  logic        i_SMPL_READY,
    output logic [15:0] o_SMPL_DATA,
    output logic        o_OVF,
    input  logic        i_OVF_CLR,
    output logic [1:0]  o_STATE
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {MUTED, RAMP, RUN, RAMP_DN} state_t;

    state_t      state, state_nx;
    logic [4:0]  cnt;
    logic        cen, frame, rhy_q, rhy;
    logic [17:0] fm_mask, ro_mask;
    logic [3:0]  mo_nx, ro_nx;
    logic        tgt_eq;
    logic        strb_q, strb_edge, push, pop, full;
    logic [AW-1:0] wp, rp;
    logic [AW:0]   fill;
    logic [15:0]   mem [FIFO_DEPTH];

    function automatic logic [3:0] toward(input logic [3:0] v, input logic [3:0] t);
        return (v < t) ? v + 4'd1 : (v > t) ? v - 4'd1 : v;
    endfunction

    assign cen   = ~i_phi1_NCEN_n;
    assign frame = cen & (cnt == 5'd17);

    // rhythm mode takes effect from slot 0 and is frozen for the rest of the frame
    assign rhy        = (cnt == 5'd0) ? i_RHYTHM_EN : rhy_q;
    assign fm_mask    = rhy ? FM_MASK_RHY : FM_MASK_MEL;
    assign ro_mask    = rhy ? RO_MASK_RHY : '0;
    assign o_CYCLE_00 = (cnt == 5'd0);
    assign o_MO_CTRL  = fm_mask[cnt];
    assign o_RO_CTRL  = ro_mask[cnt];
    assign o_DAC_EN   = (o_MO_CTRL | o_RO_CTRL) & (state != MUTED);
    assign o_STATE    = state;

    always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            cnt   <= '0;
            rhy_q <= 1'b0;
        end else begin
            if (cen) cnt <= (cnt == 5'd17) ? 5'd0 : cnt + 5'd1;
            if (cnt == 5'd0) rhy_q <= i_RHYTHM_EN;
        end
    end

    assign tgt_eq = (o_MOVOL == i_TGT_MOVOL) && (o_ROVOL == i_TGT_ROVOL);

    always_comb begin
        state_nx = state;
        mo_nx    = o_MOVOL;
        ro_nx    = o_ROVOL;
        case (state)
            MUTED:   state_nx = i_MUTE_REQ ? MUTED : RAMP;
            RAMP: begin
                state_nx = i_MUTE_REQ ? RAMP_DN : tgt_eq ? RUN : RAMP;
                mo_nx    = toward(o_MOVOL, i_TGT_MOVOL);
                ro_nx    = toward(o_ROVOL, i_TGT_ROVOL);
            end
            RUN:     state_nx = i_MUTE_REQ ? RAMP_DN : tgt_eq ? RUN : RAMP;
            RAMP_DN: begin
                state_nx = !i_MUTE_REQ ? RAMP : (o_MOVOL == 4'd0 && o_ROVOL == 4'd0) ? MUTED : RAMP_DN;
                mo_nx    = toward(o_MOVOL, 4'd0);
                ro_nx    = toward(o_ROVOL, 4'd0);
            end
            default: state_nx = MUTED;
        endcase
    end

    always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            state   <= MUTED;
            o_MOVOL <= '0;
            o_ROVOL <= '0;
        end else if (frame) begin
            state   <= state_nx;
            o_MOVOL <= mo_nx;
            o_ROVOL <= ro_nx;
        end
    end

    // history resets high so a strobe already high at reset release is ignored
    assign strb_edge    = i_ACC_STRB & ~strb_q;
    assign full         = (fill == (AW+1)'(FIFO_DEPTH));
    assign o_SMPL_VALID = (fill != '0);
    assign pop          = o_SMPL_VALID & i_SMPL_READY;
    assign push         = strb_edge & (~full | pop);
    assign o_SMPL_DATA  = mem[rp];

    always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
        if (!i_RST_n) begin
            strb_q <= 1'b1;
            wp     <= '0;
            rp     <= '0;
            fill   <= '0;
            o_OVF  <= 1'b0;
        end else begin
            strb_q <= i_ACC_STRB;
            if (push) wp <= wp + AW'(1);
            if (pop) rp <= rp + AW'(1);
            fill   <= fill + (AW+1)'(push) - (AW+1)'(pop);
            o_OVF  <= (strb_edge & ~push) ? 1'b1 : i_OVF_CLR ? 1'b0 : o_OVF;
        end
    end

    always_ff @(posedge i_EMUCLK) begin
        if (push) mem[wp] <= i_ACC_DATA;
    end
endmodule
